// File: rtl/idct_second.sv
// idct_second: decoder-side second-pass 8-point inverse DCT.
// Each input row holds 4 quantised low-frequency coefficients. The row is
// dequantised by its row index, inverse transformed, then rounded and clipped
// to 8 signed samples. The pipeline has 3 stages that advance in lock-step,
// with valid/ready handshaking on both sides.
// Optional build macro IDCT_SAT_FLAG_EN adds port sat_flag[7:0]. Bit n of
// sat_flag is set when sample n was clipped.

// One output lane: stage-2 weighted sum (registered) and stage-3 round/clip (comb).
module idct_lane #(
  parameter int C1    = 0,
  parameter int C2    = 0,
  parameter int C3    = 0,
  parameter int OUT_W = 9,
  parameter int SHIFT = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [3:0][15:0]       y,
  output logic [OUT_W-1:0]       x
`ifdef IDCT_SAT_FLAG_EN
  , output logic                 clip
`endif
);
  localparam logic signed [23:0] K0  = 24'sd45;
  localparam logic signed [23:0] K1  = 24'(C1);
  localparam logic signed [23:0] K2  = 24'(C2);
  localparam logic signed [23:0] K3  = 24'(C3);
  localparam logic signed [24:0] RND = 25'(1 << (SHIFT - 1));
  localparam logic signed [24:0] HI  = 25'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [24:0] LO  = 25'(-(1 << (OUT_W - 1)));

  logic signed [23:0] ye [4];
  logic signed [23:0] s;
  logic signed [24:0] t, q;
  logic               hi, lo;

  // Sign-extend dequantised coefficients to the accumulator width.
  always_comb begin
    for (int k = 0; k < 4; k++) ye[k] = {{8{y[k][15]}}, y[k]};
  end

  // Stage 2: S[n] = 45*Y0 + C1*Y1 + C2*Y2 + C3*Y3 (fits 24 bits for all inputs).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     s <= '0;
    else if (en) s <= K0 * ye[0] + K1 * ye[1] + K2 * ye[2] + K3 * ye[3];
  end

  // Stage 3 datapath: add half, floor shift, clip to the signed output range.
  always_comb begin
    t  = {s[23], s} + RND;
    q  = t >>> SHIFT;
    hi = q > HI;
    lo = q < LO;
    x  = q[OUT_W-1:0];
    if (hi)      x = HI[OUT_W-1:0];
    else if (lo) x = LO[OUT_W-1:0];
  end

`ifdef IDCT_SAT_FLAG_EN
  assign clip = hi | lo;
`endif
endmodule

module idct_second #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 9,
  parameter int SHIFT = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 blk_start,
  input  logic [8*IN_W-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*OUT_W-1:0]   out_data,
  output logic [2:0]           out_row
`ifdef IDCT_SAT_FLAG_EN
  , output logic [7:0]         sat_flag
`endif
);
  localparam int C1_T [8] = '{63, 53, 36, 12, -12, -36, -53, -63};
  localparam int C2_T [8] = '{59, 24, -24, -59, -59, -24, 24, 59};
  localparam int C3_T [8] = '{53, -12, -63, -36, 36, 63, 12, -53};

  logic                    en, accept;
  logic [2:0]              r, r_cur, row1, row2;
  logic [2:0]              vld_pipe;
  logic [23:0]             drow;
  logic [IN_W-1:0]         xk;
  logic [3:0][15:0]        prod, y1;
  logic [7:0][OUT_W-1:0]   x_all;
  logic                    unused_bits;

  assign unused_bits = ^in_data[4*IN_W-1:0];

  // Dequant table row, {D0,D1,D2,D3} with D0 in the top 6 bits.
  function automatic logic [23:0] d_row(input logic [2:0] ri);
    case (ri)
      3'd0:    d_row = {6'd16, 6'd11, 6'd10, 6'd16};
      3'd1:    d_row = {6'd12, 6'd12, 6'd14, 6'd19};
      3'd2:    d_row = {6'd14, 6'd13, 6'd16, 6'd24};
      3'd3:    d_row = {6'd14, 6'd17, 6'd22, 6'd29};
      3'd4:    d_row = {6'd18, 6'd22, 6'd37, 6'd56};
      3'd5:    d_row = {6'd24, 6'd35, 6'd55, 6'd63};
      3'd6:    d_row = {6'd49, 6'd63, 6'd63, 6'd63};
      default: d_row = {6'd63, 6'd63, 6'd63, 6'd63};
    endcase
  endfunction

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign accept    = in_valid && en;
  assign r_cur     = blk_start ? 3'd0 : r;
  assign out_valid = vld_pipe[2];

  // Stage 1 datapath: Yk = Xk * D[r][k]. The 16-bit signed product is exact.
  always_comb begin
    drow = d_row(r_cur);
    xk   = '0;
    prod = '0;
    for (int k = 0; k < 4; k++) begin
      xk      = in_data[8*IN_W-1-IN_W*k -: IN_W];
      prod[k] = $signed({{(16-IN_W){xk[IN_W-1]}}, xk}) * $signed({10'b0, drow[23-6*k -: 6]});
    end
  end

  // Control: the row counter advances on accept, and valids shift when the pipe moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r        <= '0;
      vld_pipe <= '0;
    end else begin
      if (accept) r <= r_cur + 3'd1;
      if (en)     vld_pipe <= {vld_pipe[1:0], in_valid};
    end
  end

  // Datapath registers. They freeze as a group while the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y1       <= '0;
      row1     <= '0;
      row2     <= '0;
      out_data <= '0;
      out_row  <= '0;
    end else if (en) begin
      y1       <= prod;
      row1     <= r_cur;
      row2     <= row1;
      out_data <= x_all;
      out_row  <= row2;
    end
  end

`ifdef IDCT_SAT_FLAG_EN
  logic [7:0] clip_all;

  // The clip flags travel with out_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     sat_flag <= '0;
    else if (en) sat_flag <= clip_all;
  end
`endif

  // x0 occupies the top field of out_data, so lane n maps to x_all[7-n].
  for (genvar n = 0; n < 8; n++) begin : g_lane
    idct_lane #(.C1(C1_T[n]), .C2(C2_T[n]), .C3(C3_T[n]), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .y    (y1),
      .x    (x_all[7-n])
`ifdef IDCT_SAT_FLAG_EN
      , .clip (clip_all[n])
`endif
    );
  end
endmodule

// File: tb/tb_idct_second.sv
// Bench for idct_second. The reference model builds the cosine weights from
// round(64*cos), applies the dequant table, and floors/clips with integer
// arithmetic. A scoreboard queue compares every output row in order.
module tb_idct_second;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, blk_start = 1'b0, out_ready = 1'b0;
  logic [79:0] in_data = '0;
  logic        in_ready, out_valid;
  logic [71:0] out_data;
  logic [2:0]  out_row;
`ifdef IDCT_SAT_FLAG_EN
  logic [7:0]  sat_flag;
`endif

  idct_second dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .blk_start(blk_start), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row)
`ifdef IDCT_SAT_FLAG_EN
    , .sat_flag(sat_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] d;
    logic [2:0]  row;
    logic [7:0]  sat;
  } exp_t;

  int   checks = 0, errors = 0;
  int   mr = 0;
  int   cf [4][8];
  int   dt [8][4] = '{'{16,11,10,16}, '{12,12,14,19}, '{14,13,16,24}, '{14,17,22,29},
                      '{18,22,37,56}, '{24,35,55,63}, '{49,63,63,63}, '{63,63,63,63}};
  exp_t sb [$];
  exp_t e;
  logic [71:0] seen_d [$];
  int          seen_r [$];
  logic [71:0] last_d, hold_d;
  logic [2:0]  last_r, hold_r;
  logic [7:0]  last_sat;
  logic        stall_prev = 1'b0;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rnd(real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  function automatic logic [79:0] pk(input int a, input int b, input int c, input int d);
    return {10'(a), 10'(b), 10'(c), 10'(d), 40'(0)};
  endfunction

  function automatic exp_t model(input logic [79:0] din, input int r);
    exp_t m;
    int   y [4];
    int   s, v;
    m.row = 3'(r); m.d = '0; m.sat = '0;
    for (int k = 0; k < 4; k++) y[k] = int'($signed(din[79-10*k -: 10])) * dt[r][k];
    for (int n = 0; n < 8; n++) begin
      s = 0;
      for (int k = 0; k < 4; k++) s += cf[k][n] * y[k];
      v = s + 64;
      v = (v >= 0) ? v / 128 : -((-v + 127) / 128);
      if (v > 255)       begin v = 255;  m.sat[n] = 1'b1; end
      else if (v < -256) begin v = -256; m.sat[n] = 1'b1; end
      m.d[71-9*n -: 9] = 9'(v);
    end
    return m;
  endfunction

  // Monitor: protocol checks, scoreboard compare, and model push. Samples 1ns after negedge.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      sb.delete(); mr = 0; stall_prev = 1'b0;
    end else begin
      chk("in_ready", 80'(in_ready), 80'(!out_valid || out_ready));
      if (stall_prev) begin
        chk("hold_valid", 80'(out_valid), 80'(1));
        chk("hold_data", 80'({out_row, out_data}), 80'({hold_r, hold_d}));
      end
      stall_prev = out_valid && !out_ready;
      hold_d = out_data; hold_r = out_row;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious_out", 80'(1), 80'(0));
        else begin
          e = sb.pop_front();
          chk("data", 80'(out_data), 80'(e.d));
          chk("row", 80'(out_row), 80'(e.row));
`ifdef IDCT_SAT_FLAG_EN
          chk("sat_flag", 80'(sat_flag), 80'(e.sat));
          last_sat = sat_flag;
`endif
          last_d = out_data; last_r = out_row;
          seen_d.push_back(out_data); seen_r.push_back(int'(out_row));
        end
      end
      if (in_valid && in_ready) begin
        if (blk_start) mr = 0;
        sb.push_back(model(in_data, mr));
        mr = (mr + 1) % 8;
      end
    end
  end

  // The caller enters at a negedge; returns at the negedge after acceptance, with in_valid still high.
  task automatic send(input logic bs, input logic [79:0] d);
    in_valid = 1'b1; blk_start = bs; in_data = d;
    for (int t = 0; t < 200; t++) begin
      #2;
      if (in_ready) begin @(negedge clk); return; end
      @(negedge clk);
    end
    chk("send_timeout", 80'(0), 80'(1));
  endtask

  task automatic drain();
    in_valid = 1'b0; blk_start = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk); #2;
      if (sb.size() == 0 && !out_valid) return;
    end
    chk("drain_timeout", 80'(sb.size()), 80'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, c;
    for (int n = 0; n < 8; n++) begin
      cf[0][n] = rnd(64.0 / $sqrt(2.0));
      for (int k = 1; k < 4; k++) cf[k][n] = rnd(64.0 * $cos(real'((2*n+1)*k) * 3.14159265358979 / 16.0));
    end

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    chk("rst_out_valid", 80'(out_valid), 80'(0));
    chk("rst_out_data", 80'(out_data), 80'(0));
    chk("rst_out_row", 80'(out_row), 80'(0));
    chk("rst_in_ready", 80'(in_ready), 80'(1));
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;

    // DC and latency
    @(negedge clk);
    in_valid = 1'b1; blk_start = 1'b1; in_data = pk(8, 0, 0, 0);
    @(negedge clk); in_valid = 1'b0; blk_start = 1'b0;
    @(negedge clk); #2 chk("lat_early", 80'(out_valid), 80'(0));
    @(negedge clk); #2 chk("lat_3clk", 80'(out_valid), 80'(1));
    chk("dc_data", 80'(out_data), 80'({8{9'd45}}));
    chk("dc_row", 80'(out_row), 80'(0));
    drain();

    // Negative DC
    @(negedge clk); send(1'b1, pk(-8, 0, 0, 0)); drain();
    chk("neg_dc", 80'(last_d), 80'({8{9'h1D3}}));

    // Saturation
    @(negedge clk); send(1'b1, pk(64, 0, 0, 0)); drain();
    chk("sat_data", 80'(last_d), 80'({8{9'h0FF}}));
`ifdef IDCT_SAT_FLAG_EN
    chk("sat_flag_all", 80'(last_sat), 80'(8'hFF));
`endif

    // Row dequant and counter wrap
    seen_d.delete(); seen_r.delete();
    @(negedge clk);
    for (int i = 0; i < 9; i++) send(i == 0, pk(0, 1, 0, 0));
    drain();
    chk("wrap_count", 80'(seen_r.size()), 80'(9));
    if (seen_r.size() == 9) begin
      for (int i = 0; i < 9; i++) chk("wrap_row", 80'(seen_r[i]), 80'(i % 8));
      chk("row7_x0", 80'(seen_d[7][71:63]), 80'(9'd31));
      chk("row7_x7", 80'(seen_d[7][8:0]), 80'(9'h1E1));
    end

    // Back-pressure over a 4-row burst
    seen_d.delete(); seen_r.delete();
    @(negedge clk); out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(i == 0, pk(i * 5 - 7, 3 - i, i, -i));
      end
      begin
        repeat (4) @(negedge clk);
        #2 chk("bp_in_ready", 80'(in_ready), 80'(0));
        @(negedge clk); out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 80'(seen_r.size()), 80'(4));

    // Reset mid-block
    @(negedge clk);
    for (int i = 0; i < 4; i++) send(i == 0, pk(i + 1, 2, 0, 1));
    in_valid = 1'b0; rst = 1'b1;
    #1;
    chk("midrst_valid", 80'(out_valid), 80'(0));
    chk("midrst_row", 80'(out_row), 80'(0));
    @(negedge clk); rst = 1'b0;
    @(negedge clk); send(1'b0, pk(8, 0, 0, 0)); drain();
    chk("post_rst_row", 80'(last_r), 80'(0));
    chk("post_rst_data", 80'(last_d), 80'({8{9'd45}}));

    // Randomised traffic with random back-pressure
    @(negedge clk);
    for (int cyc = 0; cyc < 800; cyc++) begin
      in_valid  = ($urandom % 10) < 7;
      blk_start = ($urandom % 8) == 0;
      out_ready = ($urandom % 10) < 7;
      if ($urandom % 2) begin
        a = $urandom; b = $urandom; c = $urandom;
        in_data = {a, b, c[15:0]};
      end else begin
        in_data = pk(int'($urandom_range(0, 40)) - 20, int'($urandom_range(0, 40)) - 20,
                     int'($urandom_range(0, 40)) - 20, int'($urandom_range(0, 40)) - 20);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    drain();
    chk("final_empty", 80'(sb.size()), 80'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end
endmodule
